pyrite_bpi_flash_seq: RTL

- Hardware sequencer for parallel BPI NOR flash bus cycles.
- Replaces software bit-banging of CE/OE/WE/ADV/address/data through the VSEC register window.
- Accepts one read or write command at a time on a valid/ready port and generates correctly timed async flash strobes.
- Returns one response per command. Sits between the Pyrite VSEC APB register block (or a future DMA/erase engine) and the flash pins.

---
 rtl/pyrite_bpi_seq_pkg.sv | 42 ++++
 rtl/pyrite_bpi_seq_sync.sv | 32 +++
 rtl/pyrite_bpi_flash_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pyrite_bpi_seq_pkg.sv
// -----------------------------------------------------------------------------
// pyrite_bpi_seq_pkg
// Shared types for the BPI NOR flash bus-cycle sequencer.
//   bpi_state_e : sequencer FSM states (WAIT_RDY is reachable only when the
//                 PYRITE_BPI_SEQ_RDY_EN build option is enabled)
//   bpi_cmd_t   : latched command {write, {region, addr}, data}
//   bpi_max4    : helper used to size the phase countdown counter
// The command struct is sized for the default flash geometry below; the
// sequencer parameters default to the same values.
// -----------------------------------------------------------------------------
package pyrite_bpi_seq_pkg;

    localparam int BPI_DATA_W = 16;
    localparam int BPI_ADDR_W = 23;
    localparam int BPI_RGN_W  = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ACCESS   = 3'd2,
        ST_HOLD     = 3'd3,
        ST_RECOV    = 3'd4,
        ST_RESP     = 3'd5,
        ST_WAIT_RDY = 3'd6
    } bpi_state_e;

    typedef struct packed {
        logic                            write;
        logic [BPI_RGN_W+BPI_ADDR_W-1:0] addr;
        logic [BPI_DATA_W-1:0]           data;
    } bpi_cmd_t;

    function automatic int bpi_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pyrite_bpi_seq_sync.sv
// -----------------------------------------------------------------------------
// pyrite_bpi_seq_sync
// Two-flop synchronizer for the asynchronous flash RY/BY# pin.
// Ports:
//   clk    : sampling clock
//   rst_n  : asynchronous active-low reset (output forced low)
//   i_d    : asynchronous input
//   o_q    : synchronized output, two clk edges of latency
// -----------------------------------------------------------------------------
module pyrite_bpi_seq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pyrite_bpi_flash_seq.sv
// -----------------------------------------------------------------------------
// pyrite_bpi_flash_seq
// Hardware sequencer for asynchronous parallel (BPI) NOR flash bus cycles.
// Takes one read/write command at a time and produces CE#/ADV#/OE#/WE#,
// address and data with fixed cycle timing, then returns one response.
//
// Phase sequence per command:
//   IDLE -> ADDR (T_ADDR) -> ACCESS (T_ACC) -> HOLD (T_HOLD) -> RECOV (T_RECOV)
//        [-> WAIT_RDY, writes only, with PYRITE_BPI_SEQ_RDY_EN] -> RESP -> IDLE
//
// Build option:
//   PYRITE_BPI_SEQ_RDY_EN : adds flash_ready (RY/BY#) input; after a write the
//                           sequencer waits for the synchronized ready before
//                           responding.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/ready            command handshake
//   cmd_write/addr/data        command fields (addr = {region, word addr})
//   rsp_valid/ready, rsp_data  response handshake, read data (0 for writes)
//   busy                       high whenever not IDLE
//   flash_dq_i/o, flash_dq_oe  flash data bus
//   flash_addr                 flash word address
//   flash_region(_oe)          upper region address bits and their enable
//   flash_ce_n/oe_n/we_n/adv_n active-low strobes
//   flash_ready                (option only) RY/BY# from the flash
// -----------------------------------------------------------------------------
module pyrite_bpi_flash_seq
    import pyrite_bpi_seq_pkg::*;
#(
    parameter int FLASH_DATA_W = BPI_DATA_W,
    parameter int FLASH_ADDR_W = BPI_ADDR_W,
    parameter int FLASH_RGN_W  = BPI_RGN_W,
    parameter int T_ADDR       = 2,
    parameter int T_ACC        = 4,
    parameter int T_HOLD       = 1,
    parameter int T_RECOV      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [FLASH_RGN_W+FLASH_ADDR_W-1:0] cmd_addr,
    input  logic [FLASH_DATA_W-1:0]       cmd_data,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [FLASH_DATA_W-1:0]       rsp_data,

    output logic                          busy,

`ifdef PYRITE_BPI_SEQ_RDY_EN
    input  logic                          flash_ready,
`endif
    input  logic [FLASH_DATA_W-1:0]       flash_dq_i,
    output logic [FLASH_DATA_W-1:0]       flash_dq_o,
    output logic                          flash_dq_oe,
    output logic [FLASH_ADDR_W-1:0]       flash_addr,
    output logic [FLASH_RGN_W-1:0]        flash_region,
    output logic                          flash_region_oe,
    output logic                          flash_ce_n,
    output logic                          flash_oe_n,
    output logic                          flash_we_n,
    output logic                          flash_adv_n
);

    localparam int T_MAX = bpi_max4(T_ADDR, T_ACC, T_HOLD, T_RECOV);
    localparam int CNT_W = $clog2(T_MAX) + 1;

    bpi_state_e       r_state;
    bpi_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_ld;
    logic             w_load;
    bpi_cmd_t         r_cmd;
    logic [FLASH_DATA_W-1:0] r_rsp_data;
    logic             r_live;
    logic             w_cmd_fire;
    logic             w_cnt_zero;
    logic             w_in_cycle;
    logic             w_rdy_sync;

`ifdef PYRITE_BPI_SEQ_RDY_EN
    pyrite_bpi_seq_sync u_rdy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (flash_ready),
        .o_q   (w_rdy_sync)
    );
`else
    assign w_rdy_sync = 1'b1;
`endif

    // r_live holds cmd_ready low until the first clock after reset release,
    // so command acceptance starts synchronously even though reset is async.
    assign cmd_ready  = (r_state == ST_IDLE) && r_live;
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_in_cycle = (r_state == ST_ADDR) || (r_state == ST_ACCESS) ||
                        (r_state == ST_HOLD);

    // Next-state and counter-load decode; the counter is loaded with T-1 on
    // every phase entry so each phase lasts exactly T cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cnt_ld    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    w_state_nxt = ST_ADDR;
                    w_load      = 1'b1;
                    w_cnt_ld    = CNT_W'(T_ADDR - 1);
                end
            end
            ST_ADDR: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_ACCESS;
                    w_load      = 1'b1;
                    w_cnt_ld    = CNT_W'(T_ACC - 1);
                end
            end
            ST_ACCESS: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                    w_cnt_ld    = CNT_W'(T_HOLD - 1);
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_RECOV;
                    w_load      = 1'b1;
                    w_cnt_ld    = CNT_W'(T_RECOV - 1);
                end
            end
            ST_RECOV: begin
                if (w_cnt_zero) begin
`ifdef PYRITE_BPI_SEQ_RDY_EN
                    w_state_nxt = r_cmd.write ? ST_WAIT_RDY : ST_RESP;
`else
                    w_state_nxt = ST_RESP;
`endif
                end
            end
`ifdef PYRITE_BPI_SEQ_RDY_EN
            ST_WAIT_RDY: begin
                if (w_rdy_sync) w_state_nxt = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cmd      <= '0;
            r_rsp_data <= '0;
            r_live     <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_state_nxt;
            if (w_load) begin
                r_cnt <= w_cnt_ld;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_cmd_fire) begin
                r_cmd.write <= cmd_write;
                r_cmd.addr  <= cmd_addr;
                r_cmd.data  <= cmd_data;
                r_rsp_data  <= '0;
            end
            // Read data is sampled on the final OE# low cycle, giving the
            // flash the full T_ACC window to drive DQ.
            if ((r_state == ST_ACCESS) && w_cnt_zero && !r_cmd.write) begin
                r_rsp_data <= flash_dq_i;
            end
        end
    end

    // Pin decode is purely from registered state, so an async reset returns
    // every strobe to its inactive level in the same cycle.
    assign flash_ce_n      = !w_in_cycle;
    assign flash_adv_n     = (r_state != ST_ADDR);
    assign flash_oe_n      = !((r_state == ST_ACCESS) && !r_cmd.write);
    assign flash_we_n      = !((r_state == ST_ACCESS) &&  r_cmd.write);
    assign flash_dq_oe     = w_in_cycle && r_cmd.write;
    assign flash_region_oe = w_in_cycle;
    assign flash_dq_o      = r_cmd.write ? r_cmd.data : '0;
    assign flash_addr      = r_cmd.addr[FLASH_ADDR_W-1:0];
    assign flash_region    = r_cmd.addr[FLASH_RGN_W+FLASH_ADDR_W-1:FLASH_ADDR_W];

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != ST_IDLE);

endmodule
